// File: rtl/usb_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_buf_pkg
// Description : Shared constants for the OUT-endpoint buffer drain engine:
//               FSM state encoding and default geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_buf_pkg;

    // Default geometry of the core's OUT buffer
    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_LEN_W   = 10;
    localparam int DEF_MAX_LEN = 512;

    // Output FIFO entry: {last, data[7:0]}
    localparam int c_FIFO_W = 9;

    // Drain FSM state encoding
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ARM   = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_READ  = 3'd3;
    localparam logic [2:0] c_ST_FLUSH = 3'd4;

endpackage
`default_nettype wire

// File: rtl/usb_skid_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : usb_skid_fifo2
// Description : Two-entry FIFO holding {last, data} words between the buffer
//               read port and the outgoing byte stream. Pushes into a full
//               FIFO are dropped unless a pop happens in the same cycle; the
//               caller's credit logic keeps that from occurring.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_skid_fifo2
    import usb_buf_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [c_FIFO_W-1:0] din,
    input  logic                pop,
    output logic [c_FIFO_W-1:0] dout,
    output logic [1:0]          count
);

    logic [c_FIFO_W-1:0] r_mem [2];
    logic                r_rd;
    logic                r_wr;
    logic [1:0]          r_count;
    logic                w_do_pop;
    logic                w_do_push;

    assign w_do_pop  = pop && (r_count != 2'd0);
    assign w_do_push = push && ((r_count != 2'd2) || w_do_pop);

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= din;
                r_wr        <= ~r_wr;
            end
            if (w_do_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/usb_buf_out_reader.sv
`default_nettype none
// ============================================================================
// Module      : usb_buf_out_reader
// Description : Arms the core's OUT buffer, waits for a packet, reads it out
//               through the synchronous read port and presents it as a
//               valid/ready byte stream with an end-of-packet marker.
//               Optional macro USB_BUF_OUT_STATS_EN enables the packet counter
//               and the sticky length-clamp flag; otherwise both read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_buf_out_reader
    import usb_buf_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic              ext_clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] buf_out_addr,
    input  logic [7:0]        buf_out_q,
    input  logic [LEN_W-1:0]  buf_out_len,
    input  logic              buf_out_hasdata,
    output logic              buf_out_arm,
    input  logic              buf_out_arm_ack,
    output logic [7:0]        m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [15:0]       stat_pkt_count,
    output logic              err_len_clamp
);

    logic [2:0]          r_state;
    logic                r_arm;
    logic [LEN_W-1:0]    r_cnt;
    logic [LEN_W-1:0]    r_len;
    logic                r_inflight;
    logic                r_inflight_last;

    logic [LEN_W-1:0]    w_len_clamped;
    logic [1:0]          w_count;
    logic [c_FIFO_W-1:0] w_head;
    logic                w_valid;
    logic                w_pop;
    logic [2:0]          w_credit;
    logic                w_can_issue;
    logic                w_issue_last;

    assign w_len_clamped = (buf_out_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : buf_out_len;

    assign w_valid = (w_count != 2'd0);
    assign w_pop   = w_valid && m_ready;

    // Slots committed after this cycle's pop; a byte leaving now frees its slot
    // immediately so that a continuously-ready sink sees one byte per cycle.
    assign w_credit     = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_can_issue  = (r_state == c_ST_READ) && (w_credit < 3'd2);
    assign w_issue_last = (r_cnt == (r_len - 1'b1));

    usb_skid_fifo2 u_fifo (
        .clk   (ext_clk),
        .rst   (reset),
        .push  (r_inflight),
        .din   ({r_inflight_last, buf_out_q}),
        .pop   (w_pop),
        .dout  (w_head),
        .count (w_count)
    );

    // Drain FSM: arm handshake, packet wait, address issue and final flush
    always_ff @(posedge ext_clk) begin
        if (reset) begin
            r_state         <= c_ST_IDLE;
            r_arm           <= 1'b0;
            r_cnt           <= '0;
            r_len           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (enable) begin
                        r_arm   <= 1'b1;
                        r_state <= c_ST_ARM;
                    end
                end
                c_ST_ARM: begin
                    if (buf_out_arm_ack) begin
                        r_arm   <= 1'b0;
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (buf_out_hasdata) begin
                        r_len <= w_len_clamped;
                        if (w_len_clamped == '0) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= c_ST_READ;
                        end
                    end
                end
                c_ST_READ: begin
                    if (w_can_issue) begin
                        r_inflight      <= 1'b1;
                        r_inflight_last <= w_issue_last;
                        // Counter parks on the final address so it never wraps
                        if (w_issue_last) begin
                            r_state <= c_ST_FLUSH;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_ST_FLUSH: begin
                    if (w_pop && w_head[8]) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign buf_out_addr = r_cnt[ADDR_W-1:0];
    assign buf_out_arm  = r_arm;
    assign m_data       = w_head[7:0];
    assign m_valid      = w_valid;
    assign m_last       = w_valid && w_head[8];

`ifdef USB_BUF_OUT_STATS_EN
    logic [15:0] r_pkt_count;
    logic        r_err_clamp;
    logic        w_pkt_done;
    logic        w_clamp_seen;

    assign w_pkt_done = ((r_state == c_ST_WAIT) && buf_out_hasdata && (w_len_clamped == '0))
                     || ((r_state == c_ST_FLUSH) && w_pop && w_head[8]);
    assign w_clamp_seen = (r_state == c_ST_WAIT) && buf_out_hasdata
                       && (buf_out_len > LEN_W'(MAX_LEN));

    // Wrapping drained-packet counter and sticky oversize-length flag
    always_ff @(posedge ext_clk) begin
        if (reset) begin
            r_pkt_count <= 16'd0;
            r_err_clamp <= 1'b0;
        end else begin
            if (w_pkt_done) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
            if (w_clamp_seen) begin
                r_err_clamp <= 1'b1;
            end
        end
    end

    assign stat_pkt_count = r_pkt_count;
    assign err_len_clamp  = r_err_clamp;
`else
    assign stat_pkt_count = 16'd0;
    assign err_len_clamp  = 1'b0;
`endif

endmodule
`default_nettype wire
